mhp_tx: RTL and testbench

MHP_TX -- requirements
Module: mhp_tx

---
 rtl/mhp_tx.sv | 204 ++++++++++++++++++++
 tb/tb_mhp_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mhp_tx.sv
// MHP frame transmitter: 7-byte header, unpadded payload and a 2-byte
// interleaved XOR checksum, streamed through a one-byte output register.
module mhp_tx #(
    parameter int MAX_SIZE = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_dst,
    input  logic [15:0] i_src,
    input  logic [15:0] i_size,
    input  logic [7:0]  i_dtype,
    input  logic [7:0]  i_pdata,
    input  logic        i_pvalid,
    output logic        o_pready,
    output logic [7:0]  o_wdata,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [16:0] MAX_SIZE_W = 17'(MAX_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Even-indexed bytes fold into the high checksum byte, odd into the low.
    function automatic logic [15:0] chk_fold(input logic [15:0] chk, input logic odd,
                                             input logic [7:0] b);
        chk_fold = odd ? {chk[15:8], chk[7:0] ^ b} : {chk[15:8] ^ b, chk[7:0]};
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] dst,
                                            input logic [15:0] src, input logic [15:0] size,
                                            input logic [7:0] dtype);
        case (idx)
            3'd0:    hdr_byte = dst[15:8];
            3'd1:    hdr_byte = dst[7:0];
            3'd2:    hdr_byte = src[15:8];
            3'd3:    hdr_byte = src[7:0];
            3'd4:    hdr_byte = size[15:8];
            3'd5:    hdr_byte = size[7:0];
            default: hdr_byte = dtype;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [15:0] dst_r, dst_s, src_r, src_s, size_r, size_s, cnt_r, cnt_s, chk_r, chk_s;
    logic [7:0]  dtype_r, dtype_s, wdata_r, wdata_s, hbyte_s;
    logic [2:0]  idx_r, idx_s;
    logic        par_r, par_s, wvalid_r, wvalid_s, busy_r, busy_s;
    logic        done_r, done_s, err_r, err_s, can_load_s, pready_s;

    // Next-state, datapath and output-register load decisions.
    always_comb begin
        state_s    = state_r;
        dst_s      = dst_r;
        src_s      = src_r;
        size_s     = size_r;
        dtype_s    = dtype_r;
        cnt_s      = cnt_r;
        chk_s      = chk_r;
        idx_s      = idx_r;
        par_s      = par_r;
        wdata_s    = wdata_r;
        err_s      = 1'b0;
        can_load_s = !wvalid_r || i_wready;
        wvalid_s   = wvalid_r && !i_wready;
        pready_s   = (state_r == ST_PAYLOAD) && (cnt_r != 16'd0) && can_load_s;
        hbyte_s    = hdr_byte(idx_r, dst_r, src_r, size_r, dtype_r);

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    if ({1'b0, i_size} > MAX_SIZE_W) begin
                        err_s = 1'b1;
                    end else begin
                        dst_s   = i_dst;
                        src_s   = i_src;
                        size_s  = i_size;
                        dtype_s = i_dtype;
                        cnt_s   = i_size;
                        chk_s   = 16'd0;
                        idx_s   = 3'd0;
                        par_s   = 1'b0;
                        state_s = ST_HDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (can_load_s) begin
                    wdata_s  = hbyte_s;
                    wvalid_s = 1'b1;
                    chk_s    = chk_fold(chk_r, par_r, hbyte_s);
                    par_s    = !par_r;
                    if (idx_r == 3'd6) begin
                        idx_s   = 3'd0;
                        state_s = (cnt_r != 16'd0) ? ST_PAYLOAD : ST_CHK;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (pready_s && i_pvalid) begin
                    wdata_s  = i_pdata;
                    wvalid_s = 1'b1;
                    chk_s    = chk_fold(chk_r, par_r, i_pdata);
                    par_s    = !par_r;
                    cnt_s    = cnt_r - 16'd1;
                    state_s  = (cnt_r == 16'd1) ? ST_CHK : ST_PAYLOAD;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                // idx 0/1 load the checksum bytes; idx 2 waits for the last one to leave.
                if (can_load_s) begin
                    case (idx_r)
                        3'd0: begin
                            wdata_s  = chk_r[15:8];
                            wvalid_s = 1'b1;
                            idx_s    = 3'd1;
                        end
                        3'd1: begin
                            wdata_s  = chk_r[7:0];
                            wvalid_s = 1'b1;
                            idx_s    = 3'd2;
                        end
                        default: begin
                            idx_s   = 3'd0;
                            state_s = ST_DONE;
                        end
                    endcase
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            dst_r    <= 16'd0;
            src_r    <= 16'd0;
            size_r   <= 16'd0;
            dtype_r  <= 8'd0;
            cnt_r    <= 16'd0;
            chk_r    <= 16'd0;
            idx_r    <= 3'd0;
            par_r    <= 1'b0;
            wdata_r  <= 8'd0;
            wvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            dst_r    <= dst_s;
            src_r    <= src_s;
            size_r   <= size_s;
            dtype_r  <= dtype_s;
            cnt_r    <= cnt_s;
            chk_r    <= chk_s;
            idx_r    <= idx_s;
            par_r    <= par_s;
            wdata_r  <= wdata_s;
            wvalid_r <= wvalid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
        end
    end

    assign o_pready = pready_s;
    assign o_wdata  = wdata_r;
    assign o_wvalid = wvalid_r;
    assign o_busy   = busy_r;
    assign o_done   = done_r;
    assign o_err    = err_r;

endmodule

// File: tb/tb_mhp_tx.sv
// Scoreboard bench for mhp_tx: a frame-level reference model fills a byte
// queue, and a negedge monitor pops and compares every transferred byte.
module tb_mhp_tx;
    localparam int MAX_SIZE = 1024;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_dst = 16'd0, i_src = 16'd0, i_size = 16'd0;
    logic [7:0]  i_dtype = 8'd0, i_pdata = 8'd0;
    logic        i_pvalid = 1'b0;
    logic        i_wready = 1'b1;
    logic        o_pready, o_wvalid, o_busy, o_done, o_err;
    logic [7:0]  o_wdata;

    mhp_tx #(.MAX_SIZE(MAX_SIZE)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_dst(i_dst), .i_src(i_src),
        .i_size(i_size), .i_dtype(i_dtype), .i_pdata(i_pdata), .i_pvalid(i_pvalid),
        .o_pready(o_pready), .o_wdata(o_wdata), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay[];
    int n_xfer = 0;
    int done_cnt = 0;
    int frames = 0;
    int wr_mode = 0;   // 0: ready held high, 1: toggles, 2: random
    logic stall_prev = 1'b0;
    logic [7:0] held = 8'd0;

    task automatic check(input logic ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: lays out the frame, then XORs byte k into the high/low half by k mod 2.
    task automatic model_push(input logic [15:0] dst, input logic [15:0] src,
                              input logic [15:0] size, input logic [7:0] dtype);
        logic [7:0] f[$];
        logic [7:0] hi, lo;
        f = {dst[15:8], dst[7:0], src[15:8], src[7:0], size[15:8], size[7:0], dtype};
        for (int k = 0; k < int'(size); k++) f.push_back(pay[k]);
        hi = 8'h00;
        lo = 8'h00;
        for (int k = 0; k < f.size(); k++) begin
            if (k % 2 == 0) hi = hi ^ f[k];
            else lo = lo ^ f[k];
        end
        f.push_back(hi);
        f.push_back(lo);
        foreach (f[k]) exp_q.push_back(f[k]);
    endtask

    always @(posedge i_clk) begin
        #1;
        case (wr_mode)
            0:       i_wready = 1'b1;
            1:       i_wready = ~i_wready;
            default: i_wready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: byte scoreboard, stall stability and done-pulse placement.
    always @(negedge i_clk) begin
        if (i_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check(o_wvalid && (o_wdata == held), "stall_hold", int'(o_wdata), int'(held));
            end
            if (o_wvalid && i_wready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_byte", int'(o_wdata), 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check(o_wdata == e, "wdata", int'(o_wdata), int'(e));
                end
                n_xfer++;
            end
            stall_prev = o_wvalid && !i_wready;
            held = o_wdata;
            if (o_done) begin
                check(exp_q.size() == 0, "done_early", exp_q.size(), 0);
                done_cnt++;
            end
        end
    end

    task automatic run_frame(input logic [15:0] dst, input logic [15:0] src,
                             input logic [15:0] size, input logic [7:0] dtype,
                             input int gap_lo, input int gap_hi, output int cyc);
        logic acc;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_dst = dst; i_src = src; i_size = size; i_dtype = dtype;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        frames++;
        for (int i = 0; i < int'(size); i++) begin
            repeat ($urandom_range(gap_lo, gap_hi)) begin
                i_start = 1'($urandom_range(0, 1));
                i_dst = 16'($urandom);
                @(posedge i_clk); #1;
            end
            i_start = 1'b0;
            i_pvalid = 1'b1;
            i_pdata = pay[i];
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge i_clk);
                acc = o_pready;
                @(posedge i_clk); #1;
            end
            i_pvalid = 1'b0;
            i_pdata = 8'($urandom);
            if (!acc) check(1'b0, "pready_timeout", i, int'(size));
        end
        cyc = 0;
        while (!o_done && cyc < 5000) begin
            @(negedge i_clk);
            if (!o_done) cyc++;
        end
        if (cyc >= 5000) check(1'b0, "done_timeout", cyc, 0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, errs, nb, sz;
        logic bad;
        logic [15:0] d, s;
        logic [7:0] ty;

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check(!o_wvalid && o_wdata == 8'h00 && !o_busy && !o_done && !o_err && !o_pready,
              "reset_state", {o_wvalid, o_busy, o_done, o_err, o_pready}, 0);

        // Header-only frame, checksum 83 1C, back-to-back timing.
        wr_mode = 0;
        pay = new[0];
        exp_q = {8'h00, 8'h10, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h83, 8'h83, 8'h1C};
        run_frame(16'h0010, 16'h000C, 16'd0, 8'h83, 0, 0, cyc);
        check(cyc == 10, "size0_latency", cyc, 10);

        // Two payload bytes with ready held high.
        pay = new[2];
        pay[0] = 8'hAA; pay[1] = 8'h55;
        exp_q = {8'h00, 8'h10, 8'h00, 8'h0C, 8'h00, 8'h02, 8'h83, 8'hAA, 8'h55, 8'hD6, 8'hB4};
        run_frame(16'h0010, 16'h000C, 16'd2, 8'h83, 0, 0, cyc);

        // Same frame with toggling ready and a 3-cycle payload gap.
        wr_mode = 1;
        exp_q = {8'h00, 8'h10, 8'h00, 8'h0C, 8'h00, 8'h02, 8'h83, 8'hAA, 8'h55, 8'hD6, 8'hB4};
        run_frame(16'h0010, 16'h000C, 16'd2, 8'h83, 3, 3, cyc);

        // Oversize requests are rejected with a single error pulse.
        wr_mode = 0;
        for (int r = 0; r < 2; r++) begin
            @(posedge i_clk); #1;
            i_start = 1'b1;
            i_size = (r == 0) ? 16'(MAX_SIZE + 1) : 16'hFFFF;
            @(posedge i_clk); #1;
            i_start = 1'b0;
            errs = 0;
            bad = 1'b0;
            repeat (6) begin
                @(negedge i_clk);
                if (o_err) errs++;
                if (o_wvalid || o_busy) bad = 1'b1;
            end
            check(errs == 1, "err_pulse", errs, 1);
            check(!bad, "err_quiet", int'(bad), 0);
        end

        // Randomised frames under all ready patterns.
        for (int f = 0; f < 20; f++) begin
            wr_mode = $urandom_range(0, 2);
            sz = $urandom_range(0, 24);
            pay = new[sz];
            foreach (pay[k]) pay[k] = 8'($urandom);
            d = 16'($urandom); s = 16'($urandom); ty = 8'($urandom);
            model_push(d, s, 16'(sz), ty);
            run_frame(d, s, 16'(sz), ty, 0, 3, cyc);
        end

        // Largest accepted payload.
        wr_mode = 2;
        pay = new[MAX_SIZE];
        foreach (pay[k]) pay[k] = 8'($urandom);
        model_push(16'hBEEF, 16'h1234, 16'(MAX_SIZE), 8'h5A);
        run_frame(16'hBEEF, 16'h1234, 16'(MAX_SIZE), 8'h5A, 0, 0, cyc);

        // Reset after four bytes aborts the frame without a done pulse.
        wr_mode = 0;
        pay = new[10];
        foreach (pay[k]) pay[k] = 8'($urandom);
        model_push(16'h0010, 16'h000C, 16'd10, 8'h83);
        nb = n_xfer;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_dst = 16'h0010; i_src = 16'h000C; i_size = 16'd10; i_dtype = 8'h83;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int t = 0; t < 100 && n_xfer < nb + 4; t++) @(posedge i_clk);
        check(n_xfer >= nb + 4, "pre_reset_bytes", n_xfer - nb, 4);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check(!o_wvalid && o_wdata == 8'h00 && !o_busy && !o_done && !o_err && !o_pready,
              "mid_reset_state", {o_wvalid, o_busy, o_done, o_err, o_pready}, 0);
        exp_q.delete();
        bad = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_done || o_wvalid) bad = 1'b1;
        end
        check(!bad, "abort_quiet", int'(bad), 0);

        // Fresh frame after the abort.
        wr_mode = 2;
        foreach (pay[k]) pay[k] = 8'($urandom);
        model_push(16'h0010, 16'h000C, 16'd10, 8'h83);
        run_frame(16'h0010, 16'h000C, 16'd10, 8'h83, 0, 2, cyc);

        repeat (5) @(posedge i_clk);
        check(done_cnt == frames, "done_count", done_cnt, frames);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
